// File: rtl/dm_bus_pkg.sv
// Shared definitions for the data-memory bus responder: FSM encoding,
// default register addresses and the address-decode result.
package dm_bus_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   localparam logic [31:0] DEF_LED_ADDR = 32'h0000_1000;
   localparam logic [31:0] DEF_SW_ADDR  = 32'h0000_1004;

   typedef enum logic [1:0] {
      DEC_RAM = 2'd0,
      DEC_LED = 2'd1,
      DEC_SW  = 2'd2,
      DEC_ERR = 2'd3
   } dec_e;

   // Misalignment takes priority over every target.
   function automatic dec_e decode_addr(input logic [31:0] addr,
                                        input int unsigned  ram_aw,
                                        input logic [31:0] led_addr,
                                        input logic [31:0] sw_addr);
      dec_e d;
      if (addr[1:0] != 2'b00)              d = DEC_ERR;
      else if (addr < (32'd4 << ram_aw))   d = DEC_RAM;
      else if (addr == led_addr)           d = DEC_LED;
      else if (addr == sw_addr)            d = DEC_SW;
      else                                 d = DEC_ERR;
      return d;
   endfunction

endpackage

// File: rtl/dm_bus_responder_if.sv
// Load/store request bus between the CPU core (master) and the
// data-memory responder (slave).
interface dm_bus_responder_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  be;
   logic        ack;
   logic [31:0] rdata;
   logic        err;

   modport master (output req, we, addr, wdata, be, input ack, rdata, err);
   modport slave  (input req, we, addr, wdata, be, output ack, rdata, err);
endinterface

// File: rtl/dm_word_ram.sv
// Word RAM with synchronous lane-masked write and combinational read.
module dm_word_ram #(
   parameter int AW = 6
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   input  logic [3:0]    lane_mask,
   output logic [31:0]   rdata
);

   // NOTE: the array has no reset; clearing a memory would need a per-word
   // reset network and turns the RAM into flops.
   logic [31:0] mem [2**AW];

   // NOTE: non-blocking assignment for all clocked state so every flop
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (lane_mask[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/dm_bus_responder.sv
// Data-memory bus responder: word RAM, LED register, switch register.
// Optional macro DM_BYTE_LANE_EN honours byte enables; otherwise every write is a full word.
module dm_bus_responder
   import dm_bus_pkg::*;
#(
   parameter int          RAM_AW      = 6,
   parameter int          WAIT_CYCLES = 1,
   parameter logic [31:0] LED_ADDR    = DEF_LED_ADDR,
   parameter logic [31:0] SW_ADDR     = DEF_SW_ADDR
) (
   input  logic                      clk,
   input  logic                      rst_n,
   dm_bus_responder_if.slave         bus,
   input  logic [2:0]                sw_in,
   output logic [31:0]               led_data
);

   logic [1:0]  state;
   logic [3:0]  wait_cnt;
   logic        cap_we;
   logic [31:0] cap_addr;
   logic [31:0] cap_wdata;
   logic [3:0]  lane_mask;
   logic [31:0] ram_rdata;
   logic        resp;
   logic        commit;
   dec_e        dec;

   assign dec    = decode_addr(cap_addr, RAM_AW, LED_ADDR, SW_ADDR);
   assign resp   = (state == RESP);
   assign commit = resp && cap_we;

`ifdef DM_BYTE_LANE_EN
   logic [3:0] cap_be;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          cap_be <= '0;
      else if (state == IDLE && bus.req)   cap_be <= bus.be;
   end

   assign lane_mask = cap_be;
`else
   assign lane_mask = 4'hF;
`endif

   // The request is captured once in IDLE; later field changes are ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         cap_we    <= 1'b0;
         cap_addr  <= '0;
         cap_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req) begin
                  cap_we    <= bus.we;
                  cap_addr  <= bus.addr;
                  cap_wdata <= bus.wdata;
                  if (WAIT_CYCLES > 0) begin
                     state    <= WAIT;
                     wait_cnt <= 4'(WAIT_CYCLES - 1);
                  end else begin
                     state <= RESP;
                  end
               end
            end
            WAIT: begin
               if (wait_cnt == 4'd0) state    <= RESP;
               else                  wait_cnt <= wait_cnt - 4'd1;
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_data <= '0;
      end else if (commit && dec == DEC_LED) begin
         for (int i = 0; i < 4; i++) begin
            if (lane_mask[i]) led_data[8*i +: 8] <= cap_wdata[8*i +: 8];
         end
      end
   end

   dm_word_ram #(.AW(RAM_AW)) u_ram (
      .clk       (clk),
      .we        (commit && dec == DEC_RAM),
      .addr      (cap_addr[RAM_AW+1:2]),
      .wdata     (cap_wdata),
      .lane_mask (lane_mask),
      .rdata     (ram_rdata)
   );

   assign bus.ack = resp;

   // NOTE: default every output first so no path through the case infers a latch.
   always_comb begin
      bus.rdata = '0;
      bus.err   = 1'b0;
      if (resp) begin
         case (dec)
            DEC_RAM: bus.rdata = cap_we ? 32'h0 : ram_rdata;
            DEC_LED: bus.rdata = cap_we ? 32'h0 : led_data;
            DEC_SW:  bus.rdata = cap_we ? 32'h0 : {29'b0, sw_in};
            default: bus.err   = 1'b1;
         endcase
      end
   end

endmodule

// File: tb/tb_dm_bus_responder.sv
// Self-checking bench for dm_bus_responder: three instances (WAIT_CYCLES 1, 3, 0)
// checked every cycle against a transaction-level model plus literal expectations.
module tb_dm_bus_responder;

   localparam int WC [3] = '{1, 3, 0};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  sw_in;
   logic        req_d [3];
   logic        we_d [3];
   logic [31:0] addr_d [3];
   logic [31:0] wdata_d [3];
   logic [3:0]  be_d [3];
   logic        ack_v [3];
   logic        err_v [3];
   logic [31:0] rdata_v [3];
   logic [31:0] led_v [3];

   always #5 clk = ~clk;

   dm_bus_responder_if bus0 ();
   dm_bus_responder_if bus1 ();
   dm_bus_responder_if bus2 ();

   assign bus0.req = req_d[0];  assign bus0.we = we_d[0];  assign bus0.addr = addr_d[0];
   assign bus0.wdata = wdata_d[0];  assign bus0.be = be_d[0];
   assign bus1.req = req_d[1];  assign bus1.we = we_d[1];  assign bus1.addr = addr_d[1];
   assign bus1.wdata = wdata_d[1];  assign bus1.be = be_d[1];
   assign bus2.req = req_d[2];  assign bus2.we = we_d[2];  assign bus2.addr = addr_d[2];
   assign bus2.wdata = wdata_d[2];  assign bus2.be = be_d[2];
   assign ack_v[0] = bus0.ack;  assign err_v[0] = bus0.err;  assign rdata_v[0] = bus0.rdata;
   assign ack_v[1] = bus1.ack;  assign err_v[1] = bus1.err;  assign rdata_v[1] = bus1.rdata;
   assign ack_v[2] = bus2.ack;  assign err_v[2] = bus2.err;  assign rdata_v[2] = bus2.rdata;

   dm_bus_responder #(.WAIT_CYCLES(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0), .sw_in(sw_in), .led_data(led_v[0]));
   dm_bus_responder #(.WAIT_CYCLES(3)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1), .sw_in(sw_in), .led_data(led_v[1]));
   dm_bus_responder #(.WAIT_CYCLES(0)) dut2 (
      .clk(clk), .rst_n(rst_n), .bus(bus2), .sw_in(sw_in), .led_data(led_v[2]));

   typedef struct {
      int          dut;
      int          cyc;
      logic [31:0] rdata;
      logic        err;
      bit          ram_wr;
      bit          led_wr;
      int          idx;
      logic [31:0] wval;
      logic [3:0]  mask;
   } txn_t;

   txn_t        pend [$];
   logic [31:0] m_ram [3][64];
   logic [31:0] m_led [3];
   int          cyc = 0;
   int          n_checks = 0;
   int          n_err = 0;
   bit          chk_en = 1'b0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] mask);
      logic [31:0] r = old;
      for (int i = 0; i < 4; i++) if (mask[i]) r[8*i +: 8] = nw[8*i +: 8];
      return r;
   endfunction

   // Expected response of one transaction from the memory-map rules and current model state.
   function automatic txn_t model_txn(input int k, input bit w, input logic [31:0] a,
                                      input logic [31:0] d, input logic [3:0] b, input int ack_cyc);
      txn_t t;
      t.dut = k;  t.cyc = ack_cyc;  t.rdata = 32'h0;  t.err = 1'b0;
      t.ram_wr = 1'b0;  t.led_wr = 1'b0;  t.idx = 0;  t.wval = d;
      t.mask = b;
`ifndef DM_BYTE_LANE_EN
      t.mask = 4'hF;
`endif
      if (a % 4 != 0) t.err = 1'b1;
      else if (a < 256) begin
         t.idx = int'(a / 4);
         if (w) t.ram_wr = 1'b1; else t.rdata = m_ram[k][t.idx];
      end else if (a == 32'h1000) begin
         if (w) t.led_wr = 1'b1; else t.rdata = m_led[k];
      end else if (a == 32'h1004) begin
         if (!w) t.rdata = {29'b0, sw_in};
      end else t.err = 1'b1;
      return t;
   endfunction

   task automatic model_reset();
      pend.delete();
      for (int k = 0; k < 3; k++) m_led[k] = 32'h0;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 3; k++) begin
            int   hit;
            txn_t t;
            hit = -1;
            check($sformatf("led_dut%0d", k), led_v[k], m_led[k]);
            foreach (pend[i]) if (pend[i].dut == k && pend[i].cyc == cyc) hit = i;
            if (hit >= 0) begin
               t = pend[hit];
               check($sformatf("ack_dut%0d", k), {31'b0, ack_v[k]}, 32'd1);
               check($sformatf("rdata_dut%0d", k), rdata_v[k], t.rdata);
               check($sformatf("err_dut%0d", k), {31'b0, err_v[k]}, {31'b0, t.err});
               if (t.ram_wr) m_ram[k][t.idx] = merge(m_ram[k][t.idx], t.wval, t.mask);
               if (t.led_wr) m_led[k] = merge(m_led[k], t.wval, t.mask);
               pend.delete(hit);
            end else begin
               check($sformatf("idle_ack_dut%0d", k), {31'b0, ack_v[k]}, 32'd0);
               check($sformatf("idle_rdata_dut%0d", k), rdata_v[k], 32'h0);
               check($sformatf("idle_err_dut%0d", k), {31'b0, err_v[k]}, 32'd0);
            end
         end
      end
   end

   // Issues one transaction and returns the outputs seen in the expected ack cycle.
   task automatic xfer(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, output logic [31:0] rd, output logic er, output logic ak);
      @(posedge clk); #1;
      req_d[k] = 1'b1;  we_d[k] = w;  addr_d[k] = a;  wdata_d[k] = d;  be_d[k] = b;
      pend.push_back(model_txn(k, w, a, d, b, cyc + WC[k] + 1));
      repeat (WC[k] + 1) @(posedge clk);
      #1 req_d[k] = 1'b0;
      @(negedge clk);
      rd = rdata_v[k];  er = err_v[k];  ak = ack_v[k];
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish, got running, expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] rd;
      logic        er;
      logic        ak;
      logic [31:0] exp_lane;
      logic [31:0] exp_be0;
      logic [31:0] exp_led;

      sw_in = 3'b000;
      for (int k = 0; k < 3; k++) begin
         req_d[k] = 1'b0;  we_d[k] = 1'b0;  addr_d[k] = '0;  wdata_d[k] = '0;  be_d[k] = 4'hF;
      end
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("rst_ack_dut%0d", k), {31'b0, ack_v[k]}, 32'd0);
         check($sformatf("rst_rdata_dut%0d", k), rdata_v[k], 32'h0);
         check($sformatf("rst_err_dut%0d", k), {31'b0, err_v[k]}, 32'd0);
         check($sformatf("rst_led_dut%0d", k), led_v[k], 32'h0);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      chk_en = 1'b1;

      // RAM write then read, two-cycle latency on WAIT_CYCLES=1.
      xfer(0, 1, 32'h10, 32'h1234_5678, 4'hF, rd, er, ak);
      check("wr_ram_ack", {31'b0, ak}, 32'd1);
      xfer(0, 0, 32'h10, 32'h0, 4'hF, rd, er, ak);
      check("rd_ram_ack", {31'b0, ak}, 32'd1);
      check("rd_ram_data", rd, 32'h1234_5678);
      check("rd_ram_err", {31'b0, er}, 32'd0);

      // LED register and switch register.
      xfer(0, 1, 32'h1000, 32'hDEAD_BEEF, 4'hF, rd, er, ak);
      @(negedge clk);
      check("led_after_wr", led_v[0], 32'hDEAD_BEEF);
      sw_in = 3'b101;
      xfer(0, 0, 32'h1004, 32'h0, 4'hF, rd, er, ak);
      check("rd_sw_data", rd, 32'h0000_0005);
      xfer(0, 1, 32'h1004, 32'h5555_5555, 4'hF, rd, er, ak);
      check("wr_sw_err", {31'b0, er}, 32'd0);
      @(negedge clk);
      check("led_after_sw_wr", led_v[0], 32'hDEAD_BEEF);

      // Misaligned and unmapped accesses leave RAM and LED untouched.
      xfer(0, 0, 32'h12, 32'h0, 4'hF, rd, er, ak);
      check("misalign_err", {31'b0, er}, 32'd1);
      check("misalign_rdata", rd, 32'h0);
      xfer(0, 0, 32'h2000, 32'h0, 4'hF, rd, er, ak);
      check("unmapped_err", {31'b0, er}, 32'd1);
      check("unmapped_rdata", rd, 32'h0);
      xfer(0, 1, 32'h12, 32'hFFFF_FFFF, 4'hF, rd, er, ak);
      xfer(0, 1, 32'h1002, 32'hFFFF_FFFF, 4'hF, rd, er, ak);
      xfer(0, 1, 32'h100, 32'hFFFF_FFFF, 4'hF, rd, er, ak);
      check("past_ram_err", {31'b0, er}, 32'd1);
      xfer(0, 0, 32'h10, 32'h0, 4'hF, rd, er, ak);
      check("ram_kept", rd, 32'h1234_5678);
      check("led_kept", led_v[0], 32'hDEAD_BEEF);

      // Last RAM word.
      xfer(0, 1, 32'hFC, 32'hCAFE_0001, 4'hF, rd, er, ak);
      xfer(0, 0, 32'hFC, 32'h0, 4'hF, rd, er, ak);
      check("last_word", rd, 32'hCAFE_0001);

      // Byte lanes on RAM and LED.
`ifdef DM_BYTE_LANE_EN
      exp_lane = 32'hAA22_CC44;  exp_be0 = 32'hAA22_CC44;  exp_led = 32'hDEAD_FFFF;
`else
      exp_lane = 32'h1122_3344;  exp_be0 = 32'h0000_0000;  exp_led = 32'hFFFF_FFFF;
`endif
      xfer(0, 1, 32'h0, 32'hAABB_CCDD, 4'hF, rd, er, ak);
      xfer(0, 1, 32'h0, 32'h1122_3344, 4'b0101, rd, er, ak);
      xfer(0, 0, 32'h0, 32'h0, 4'hF, rd, er, ak);
      check("lane_rd", rd, exp_lane);
      xfer(0, 1, 32'h0, 32'h0000_0000, 4'b0000, rd, er, ak);
      check("be0_err", {31'b0, er}, 32'd0);
      xfer(0, 0, 32'h0, 32'h0, 4'hF, rd, er, ak);
      check("be0_rd", rd, exp_be0);
      xfer(0, 1, 32'h1000, 32'hFFFF_FFFF, 4'b0011, rd, er, ak);
      @(negedge clk);
      check("led_lane", led_v[0], exp_led);

      // WAIT_CYCLES=0: req held three cycles gives two acks on alternate cycles.
      xfer(2, 1, 32'h20, 32'h0BAD_F00D, 4'hF, rd, er, ak);
      @(posedge clk); #1;
      req_d[2] = 1'b1;  we_d[2] = 1'b0;  addr_d[2] = 32'h20;  be_d[2] = 4'hF;
      pend.push_back(model_txn(2, 0, 32'h20, 32'h0, 4'hF, cyc + 1));
      pend.push_back(model_txn(2, 0, 32'h20, 32'h0, 4'hF, cyc + 3));
      @(posedge clk); @(negedge clk);
      check("b2b_ack1", {31'b0, ack_v[2]}, 32'd1);
      check("b2b_data1", rdata_v[2], 32'h0BAD_F00D);
      @(posedge clk); @(negedge clk);
      check("b2b_gap_ack", {31'b0, ack_v[2]}, 32'd0);
      check("b2b_gap_rdata", rdata_v[2], 32'h0);
      @(posedge clk); #1 req_d[2] = 1'b0;
      @(negedge clk);
      check("b2b_ack2", {31'b0, ack_v[2]}, 32'd1);
      check("b2b_data2", rdata_v[2], 32'h0BAD_F00D);
      repeat (3) @(posedge clk);

      // WAIT_CYCLES=3: reset during WAIT drops the pending write.
      xfer(1, 1, 32'h4, 32'h00C0_FFEE, 4'hF, rd, er, ak);
      check("wc3_wr_ack", {31'b0, ak}, 32'd1);
      xfer(1, 1, 32'h1000, 32'h0000_0077, 4'hF, rd, er, ak);
      @(posedge clk); #1;
      req_d[1] = 1'b1;  we_d[1] = 1'b1;  addr_d[1] = 32'h4;  wdata_d[1] = 32'hFFFF_FFFF;  be_d[1] = 4'hF;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b0;
      req_d[1] = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("abort_led", led_v[1], 32'h0);
      xfer(1, 0, 32'h4, 32'h0, 4'hF, rd, er, ak);
      check("abort_ack_latency", {31'b0, ak}, 32'd1);
      check("abort_word_kept", rd, 32'h00C0_FFEE);
      repeat (4) @(posedge clk);

      check("model_drained", pend.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
